// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to compute multiplies with one combinational product instead of iterating.
module rv_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic              special_q, special_d;
   logic              fast_q, fast_d;
   logic [XLEN-1:0]   mag_a_q, mag_a_d;
   logic [XLEN-1:0]   mag_b_q, mag_b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              a_signed, b_signed, in_sign_a, in_sign_b;
   logic              is_div, div_zero, div_ovf, fast_req;
   logic [XLEN-1:0]   in_mag_a, in_mag_b, special_val;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] fast_prod, prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_val;

`ifdef MULDIV_FAST_MUL_EN
   assign fast_req  = 1'b1;
   assign fast_prod = {{XLEN{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, mag_b_q};
`else
   assign fast_req  = 1'b0;
   assign fast_prod = '0;
`endif

   // Operand decode at issue: signedness, magnitudes and the results that bypass iteration.
   always_comb begin
      a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      in_sign_a   = a_signed & a[XLEN-1];
      in_sign_b   = b_signed & b[XLEN-1];
      in_mag_a    = in_sign_a ? -a : a;
      in_mag_b    = in_sign_b ? -b : b;
      is_div      = funct3[2];
      div_zero    = is_div && (b == '0);
      div_ovf     = is_div && !funct3[0] && (a == INT_MIN) && (b == '1);
      special_val = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : INT_MIN);
   end

   // Datapath: multiply keeps the multiplier in acc low half; divide keeps remainder:quotient in acc.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, mag_b_q};
      prod      = fast_q ? fast_prod : acc_q;
      prod_s    = (sign_a_q ^ sign_b_q) ? -prod : prod;
      quo_s     = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_s     = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (special_q)
         fix_val = acc_q[XLEN-1:0];
      else if (!op_q[2])
         fix_val = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      else
         fix_val = op_q[1] ? rem_s : quo_s;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      special_d = special_q;
      fast_d    = fast_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      acc_d     = acc_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               op_d      = funct3;
               sign_a_d  = in_sign_a;
               sign_b_d  = in_sign_b;
               mag_a_d   = in_mag_a;
               mag_b_d   = in_mag_b;
               special_d = div_zero || div_ovf;
               fast_d    = fast_req && !is_div;
               cnt_d     = '0;
               if (div_zero || div_ovf)
                  acc_d = {{XLEN{1'b0}}, special_val};
               else if (is_div)
                  acc_d = {{XLEN{1'b0}}, in_mag_a};
               else
                  acc_d = {{XLEN{1'b0}}, in_mag_b};
               state_d = (div_zero || div_ovf || (fast_req && !is_div)) ? S_FIX : S_RUN;
            end
         end
         S_RUN: begin
            if (op_q[2])
               acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
               acc_d = {mul_sum, acc_q[XLEN-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1))
               state_d = S_FIX;
         end
         S_FIX: begin
            result_d = fix_val;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         special_q <= 1'b0;
         fast_q    <= 1'b0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         special_q <= special_d;
         fast_q    <= fast_d;
         mag_a_q   <= mag_a_d;
         mag_b_q   <= mag_b_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Testbench for rv_muldiv_unit: directed vector table, randomized ops vs a reference model,
// and hand-written handshake / reset sequences.
module tb_rv_muldiv_unit;
   localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;
   bit busy_bad;

   rv_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
   } vec_t;

   // RV32M semantics written directly with wide signed/unsigned arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy;
      logic [63:0] ux, uy, p;
      int          qx, qy;
      logic [31:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      qx = x;
      qy = y;
      case (f)
         3'd0: begin p = ux * uy;             r = p[31:0];  end
         3'd1: begin p = sx * sy;             r = p[63:32]; end
         3'd2: begin p = sx * longint'(uy);   r = p[63:32]; end
         3'd3: begin p = ux * uy;             r = p[63:32]; end
         3'd4: begin
            if (y == 0) r = 32'hFFFFFFFF;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
            else r = 32'(qx / qy);
         end
         3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
         3'd6: begin
            if (y == 0) r = x;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
            else r = 32'(qx % qy);
         end
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   // Edges counted after the accepting edge until done is seen.
   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      bit special;
      special = f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
      return (special || (FAST && !f[2])) ? 1 : 33;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; funct3 = f; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      busy_bad = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!done && !busy) busy_bad = 1'b1;
      end while (!done && n < 100);
      if (!done) n = -1;
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
      int n;
      issue(f, x, y);
      wait_done(n);
      $display("[TB] %s f=%0d a=%h b=%h -> %h after %0d edges", name, f, x, y, result, n);
      check_int({name, " latency"}, n, exp_lat(f, x, y));
      check({name, " result"}, result, exp);
      check({name, " busy-while-running"}, 32'(busy_bad), 32'd0);
      check({name, " busy-at-done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({name, " done-one-cycle"}, 32'(done), 32'd0);
      check({name, " result-held"}, result, exp);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   vec_t vecs[16];

   initial begin
      int n;
      logic [2:0]  rf;
      logic [31:0] rx, ry;
      bit          idle_done;

      vecs[0]  = '{"MUL 7*-3",          3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
      vecs[1]  = '{"MULH min*min",      3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
      vecs[2]  = '{"MULHU max*max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[3]  = '{"MULHSU -1*max",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[4]  = '{"DIV -7/2",          3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
      vecs[5]  = '{"REM -7/2",          3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
      vecs[6]  = '{"DIVU 100/7",        3'd5, 32'd100,      32'd7,        32'd14};
      vecs[7]  = '{"REMU 100/7",        3'd7, 32'd100,      32'd7,        32'd2};
      vecs[8]  = '{"DIV 7/-2",          3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
      vecs[9]  = '{"REM 7/-2",          3'd6, 32'd7,        32'hFFFFFFFE, 32'd1};
      vecs[10] = '{"DIV 5/0",           3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
      vecs[11] = '{"REMU 5/0",          3'd7, 32'd5,        32'd0,        32'd5};
      vecs[12] = '{"DIV ovf",           3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      vecs[13] = '{"REM ovf",           3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
      vecs[14] = '{"DIVU 5/0",          3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
      vecs[15] = '{"REM 5/0",           3'd6, 32'd5,        32'd0,        32'd5};

      // Reset state before release.
      #12;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_done = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (done || busy) idle_done = 1'b1;
      end
      check("idle without start", 32'(idle_done), 32'd0);

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].exp);

      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         rx = pick_operand();
         ry = pick_operand();
         run_op($sformatf("rand%0d", i), rf, rx, ry, ref_model(rf, rx, ry));
      end

      // A start pulse while busy must not disturb the in-flight divide.
      issue(3'd5, 32'd100, 32'd7);
      n = 0;
      busy_bad = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!done && !busy) busy_bad = 1'b1;
         if (n == 5) begin
            start = 1'b1; funct3 = 3'd0; a = 32'd9; b = 32'd3;
         end else begin
            start = 1'b0;
         end
      end while (!done && n < 100);
      if (!done) n = -1;
      $display("[TB] DIVU 100/7 with stray start -> %h after %0d edges", result, n);
      check_int("ignored-start latency", n, 33);
      check("ignored-start result", result, 32'd14);
      check("ignored-start busy", 32'(busy_bad), 32'd0);

      // start held high through the DONE cycle issues a second op back-to-back.
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd4;
      @(posedge clk);
      #1;
      wait_done(n);
      $display("[TB] MUL 3*4 first -> %h after %0d edges", result, n);
      check_int("b2b first latency", n, exp_lat(3'd0, 32'd3, 32'd4));
      check("b2b first result", result, 32'd12);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b accepted busy", 32'(busy), 32'd1);
      check("b2b accepted done", 32'(done), 32'd0);
      wait_done(n);
      $display("[TB] MUL 3*4 second -> %h after %0d edges", result, n);
      check_int("b2b second latency", n, exp_lat(3'd0, 32'd3, 32'd4));
      check("b2b second result", result, 32'd12);

      // Asynchronous reset in the middle of a divide.
      issue(3'd4, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #4;
      rst_n = 1'b0;
      #1;
      $display("[TB] reset mid-DIV busy=%0b done=%0b result=%h", busy, done, result);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("DIV 20/4 after reset", 3'd4, 32'd20, 32'd4, 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
